// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU controller.
//   - Instruction opcodes (IR[15:12])
//   - ALU command codes driven on alu_s
//   - Controller state type
package cpu_pkg;

  // Instruction opcodes
  localparam logic [3:0] OP_CLA = 4'h0;
  localparam logic [3:0] OP_COM = 4'h1;
  localparam logic [3:0] OP_SHR = 4'h2;
  localparam logic [3:0] OP_CSL = 4'h3;
  localparam logic [3:0] OP_STP = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_STA = 4'h6;
  localparam logic [3:0] OP_LDA = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_BAN = 4'h9;

  // ALU idles in pass-through whenever no operation is executing
  localparam logic [3:0] ALU_PASS = 4'b0110;

  typedef enum logic [2:0] {
    ST_IF,
    ST_DEC,
    ST_EX,
    ST_RD,
    ST_WR,
    ST_HALT
  } state_e;

  // Opcodes whose result comes straight from the ALU without a memory operand
  function automatic logic is_reg_op(input logic [3:0] op);
    return (op == OP_CLA) || (op == OP_COM) || (op == OP_SHR) || (op == OP_CSL);
  endfunction

endpackage

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit accumulator CPU.
// Owns PC, IR, ACC, MBR and the carry/zero flags, fetches 16-bit
// instructions over a req/ack memory port and sequences an external ALU.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   mem_req/we/addr     memory request, held stable until mem_ack
//   mem_wdata           store data (ACC)
//   mem_rdata, mem_ack  read data and 1-cycle completion strobe
//   alu_s/a/b           ALU opcode and operands (a = ACC, b = MBR)
//   alu_result/cf/zf    ALU result and flags
//   halted              set once STP has been decoded
//   acc, pc             observation of accumulator and program counter
module cpu_ctrl_seq
  import cpu_pkg::*;
#(
  parameter int unsigned   AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [15:0]   mem_rdata,
  input  logic          mem_ack,
  output logic [3:0]    alu_s,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  input  logic [7:0]    alu_result,
  input  logic          alu_cf,
  input  logic          alu_zf,
  output logic          halted,
  output logic [7:0]    acc,
  output logic [AW-1:0] pc
);

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    acc_q;
  logic [7:0]    mbr_q;
  logic [3:0]    ir_op_q;
  logic [7:0]    ir_addr_q;
  logic [3:0]    alu_s_q;
  logic          cf_q;
  logic          zf_q;
  logic          req_q;
  logic          we_q;
  logic          halted_q;

  logic [AW-1:0] pc_inc_d;
  logic [AW-1:0] opnd_addr_d;
  logic [AW-1:0] branch_addr_d;

  assign pc_inc_d    = pc_q + 1'b1;
  assign opnd_addr_d = AW'(ir_addr_q);

  // JMP always redirects; BAN only when ACC is negative, otherwise the
  // already-incremented PC is the fall-through address.
  assign branch_addr_d = ((ir_op_q == OP_JMP) || acc_q[7]) ? opnd_addr_d : pc_q;

  // Flags and IR[11:8] have no consumer on this block's ports.
  logic unused_ok;
  assign unused_ok = ^{mem_rdata[11:8], cf_q, zf_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IF;
      pc_q      <= RESET_PC;
      addr_q    <= '0;
      acc_q     <= '0;
      mbr_q     <= '0;
      ir_op_q   <= '0;
      ir_addr_q <= '0;
      alu_s_q   <= ALU_PASS;
      cf_q      <= 1'b0;
      zf_q      <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IF: begin
          // Request is raised here only for the first fetch after reset;
          // every other entry into IF already arrives with the request set.
          if (!req_q) begin
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= pc_q;
          end else if (mem_ack) begin
            ir_op_q   <= mem_rdata[15:12];
            ir_addr_q <= mem_rdata[7:0];
            pc_q      <= pc_inc_d;
            req_q     <= 1'b0;
            state_q   <= ST_DEC;
          end
        end

        ST_DEC: begin
          if (is_reg_op(ir_op_q)) begin
            alu_s_q <= ir_op_q;
            state_q <= ST_EX;
          end else begin
            case (ir_op_q)
              OP_ADD, OP_LDA: begin
                req_q   <= 1'b1;
                we_q    <= 1'b0;
                addr_q  <= opnd_addr_d;
                state_q <= ST_RD;
              end
              OP_STA: begin
                req_q   <= 1'b1;
                we_q    <= 1'b1;
                addr_q  <= opnd_addr_d;
                state_q <= ST_WR;
              end
              OP_JMP, OP_BAN: begin
                pc_q    <= branch_addr_d;
                req_q   <= 1'b1;
                we_q    <= 1'b0;
                addr_q  <= branch_addr_d;
                state_q <= ST_IF;
              end
              OP_STP: begin
                halted_q <= 1'b1;
                state_q  <= ST_HALT;
              end
              default: begin
                req_q   <= 1'b1;
                we_q    <= 1'b0;
                addr_q  <= pc_q;
                state_q <= ST_IF;
              end
            endcase
          end
        end

        ST_RD: begin
          if (mem_ack) begin
            mbr_q   <= mem_rdata[7:0];
            req_q   <= 1'b0;
            alu_s_q <= ir_op_q;
            state_q <= ST_EX;
          end
        end

        ST_EX: begin
          acc_q <= alu_result;
          if (ir_op_q == OP_ADD) begin
            cf_q <= alu_cf;
            zf_q <= alu_zf;
          end
          alu_s_q <= ALU_PASS;
          req_q   <= 1'b1;
          we_q    <= 1'b0;
          addr_q  <= pc_q;
          state_q <= ST_IF;
        end

        ST_WR: begin
          // Store done: the request line stays up and turns directly into
          // the next instruction fetch.
          if (mem_ack) begin
            we_q    <= 1'b0;
            addr_q  <= pc_q;
            state_q <= ST_IF;
          end
        end

        ST_HALT: begin
        end

        default: state_q <= ST_IF;
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = acc_q;
  assign alu_s     = alu_s_q;
  assign alu_a     = acc_q;
  assign alu_b     = mbr_q;
  assign halted    = halted_q;
  assign acc       = acc_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq: memory responder with random wait
// states and spurious acks, an ALU stand-in, and an instruction-level model
// that predicts every memory transaction, its start cycle, and the halt point.
module tb_cpu_ctrl_seq;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [3:0]  alu_s;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_result;
  logic        alu_cf;
  logic        alu_zf;
  logic        halted;
  logic [7:0]  acc;
  logic [7:0]  pc;

  cpu_ctrl_seq #(.AW(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_cf(alu_cf), .alu_zf(alu_zf),
    .halted(halted), .acc(acc), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
    alu_cf     = 1'b0;
    case (alu_s)
      4'd0:    alu_result = 8'h00;
      4'd1:    alu_result = ~alu_a;
      4'd2:    alu_result = {alu_a[7], alu_a[7:1]};
      4'd3:    alu_result = {alu_a[6:0], alu_a[7]};
      4'd5:    begin alu_result = alu_sum[7:0]; alu_cf = alu_sum[8]; end
      4'd7:    alu_result = alu_b;
      default: alu_result = alu_a;
    endcase
    alu_zf = (alu_result == 8'h00);
  end

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] eacc;
    int         gap;
    bit         fetch;
    bit         halt_after;
  } txn_t;

  logic [15:0] mem [256];
  logic [15:0] mm  [256];
  logic [7:0]  mpc, macc;
  bit          mhalt;
  txn_t        expq[$];
  txn_t        cur;
  int          pend_gap, halt_at, cyc, last_ack;
  bit          in_txn;
  bit          h_we;
  logic [7:0]  h_addr, h_wdata;
  int          cnt, dly;
  int          total, bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cyc=%0d t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask

  // Execute one instruction at ISA level and queue the transactions it implies.
  task automatic model_step();
    logic [15:0] ins;
    logic [3:0]  op;
    logic [7:0]  a;
    txn_t        f, d;
    ins = mm[mpc];
    op  = ins[15:12];
    a   = ins[7:0];
    f.we = 1'b0; f.addr = mpc; f.wdata = 8'h00; f.eacc = macc;
    f.gap = pend_gap; f.fetch = 1'b1; f.halt_after = 1'b0;
    d.we = 1'b0; d.addr = a; d.wdata = 8'h00; d.eacc = 8'h00;
    d.gap = 2; d.fetch = 1'b0; d.halt_after = 1'b0;
    mpc = mpc + 8'd1;
    case (op)
      4'h0: begin macc = 8'h00;               pend_gap = 3; end
      4'h1: begin macc = ~macc;               pend_gap = 3; end
      4'h2: begin macc = {macc[7], macc[7:1]}; pend_gap = 3; end
      4'h3: begin macc = {macc[6:0], macc[7]}; pend_gap = 3; end
      4'h4: begin f.halt_after = 1'b1; mhalt = 1'b1; end
      4'h5: begin macc = macc + mm[a][7:0];   pend_gap = 2; end
      4'h7: begin macc = mm[a][7:0];          pend_gap = 2; end
      4'h6: begin d.we = 1'b1; d.wdata = macc; mm[a] = {8'h00, macc}; pend_gap = 1; end
      4'h8: begin mpc = a;                    pend_gap = 2; end
      4'h9: begin if (macc[7]) mpc = a;       pend_gap = 2; end
      default:                                pend_gap = 2;
    endcase
    expq.push_back(f);
    if (op == 4'h5 || op == 4'h7 || op == 4'h6) expq.push_back(d);
  endtask

  // One clock: check at the falling edge, then drive the memory response.
  task automatic tick(input int dmode);
    @(negedge clk);
    cyc++;
    chk("alu_s_illegal", (alu_s == 4'd4) || (alu_s == 4'd9), 0);
    chk("halted", halted, (halt_at >= 0) && (cyc >= halt_at));
    if (halt_at >= 0 && cyc >= halt_at) chk("halt_no_req", mem_req, 0);
    if (mem_req === 1'b1) begin
      if (!in_txn) begin
        cur.fetch = 1'b0;
        cur.halt_after = 1'b0;
        if (expq.size() == 0) begin
          if (mhalt) chk("req_after_stp", mem_req, 0);
          else model_step();
        end
        if (expq.size() != 0) begin
          cur = expq.pop_front();
          chk("txn_we", mem_we, cur.we);
          chk("txn_addr", mem_addr, cur.addr);
          if (cur.we) chk("txn_wdata", mem_wdata, cur.wdata);
          if (cur.gap >= 0) chk("txn_gap", cyc - last_ack, cur.gap);
          if (cur.fetch) begin
            chk("fetch_pc", pc, cur.addr);
            chk("fetch_acc", acc, cur.eacc);
          end
        end
        in_txn  = 1'b1;
        h_we    = mem_we;
        h_addr  = mem_addr;
        h_wdata = mem_wdata;
        cnt     = 0;
        dly     = (dmode < 0) ? int'($urandom_range(0, 3)) : dmode;
      end else begin
        chk("hold_we", mem_we, h_we);
        chk("hold_addr", mem_addr, h_addr);
        if (h_we) chk("hold_wdata", mem_wdata, h_wdata);
      end
      if (cnt == dly) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem[mem_addr] = {8'h00, mem_wdata};
          mem_rdata = 16'($urandom);
        end else begin
          mem_rdata = mem[mem_addr];
        end
        in_txn   = 1'b0;
        last_ack = cyc;
        if (cur.halt_after) halt_at = cyc + 2;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        cnt++;
      end
    end else begin
      if (in_txn) begin
        chk("req_held", mem_req, 1);
        in_txn = 1'b0;
      end
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = 16'($urandom);
    end
  endtask

  task automatic start();
    rst = 1'b1;
    mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_acc", acc, 8'h00);
    chk("rst_halted", halted, 0);
    chk("rst_alu_s", alu_s, 4'b0110);
    for (int i = 0; i < 256; i++) mm[i] = mem[i];
    mpc = 8'h00; macc = 8'h00; mhalt = 1'b0;
    expq.delete();
    in_txn = 1'b0; pend_gap = -1; halt_at = -1; cyc = 0; last_ack = 0;
    cur.fetch = 1'b0; cur.halt_after = 1'b0;
    rst = 1'b0;
  endtask

  task automatic run(input int dmode, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      tick(dmode);
      if (halt_at >= 0 && cyc > halt_at + 3) break;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h4000;
  endtask

  task automatic load_p1();
    clear_mem();
    mem[0] = 16'h7010; mem[1] = 16'h5011; mem[2] = 16'h6012; mem[3] = 16'h4000;
    mem[8'h10] = 16'h00FF; mem[8'h11] = 16'h0001; mem[8'h12] = 16'h00AA;
  endtask

  task automatic check_p1(input string tag);
    chk({tag, "_halted"}, halted, 1);
    chk({tag, "_acc"}, acc, 8'h00);
    chk({tag, "_m12"}, mem[8'h12], 16'h0000);
    chk({tag, "_pc"}, pc, 8'h04);
  endtask

  task automatic load_branch(input logic [15:0] mval);
    clear_mem();
    mem[0] = 16'h7030; mem[1] = 16'h9020; mem[2] = 16'h4000; mem[8'h20] = 16'h4000;
    mem[8'h30] = mval;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;

    // LDA/ADD/STA overflow program, every access held off 3 cycles
    load_p1();
    start();
    run(3, 300);
    check_p1("p1");

    // Rotate / shift / complement / clear chain
    clear_mem();
    mem[0] = 16'h7030; mem[1] = 16'h3000; mem[2] = 16'h6040; mem[3] = 16'h2000;
    mem[4] = 16'h6041; mem[5] = 16'h1000; mem[6] = 16'h6042; mem[7] = 16'h0000;
    mem[8] = 16'h6043; mem[9] = 16'h4000; mem[8'h30] = 16'h0081;
    start();
    run(-1, 300);
    chk("p2_halted", halted, 1);
    chk("p2_csl", mem[8'h40], 16'h0003);
    chk("p2_shr", mem[8'h41], 16'h0001);
    chk("p2_com", mem[8'h42], 16'h00FE);
    chk("p2_cla", mem[8'h43], 16'h0000);
    chk("p2_pc", pc, 8'h0A);

    // BAN taken / not taken
    load_branch(16'h0080);
    start();
    run(0, 200);
    chk("ban_taken_pc", pc, 8'h21);
    chk("ban_taken_acc", acc, 8'h80);
    load_branch(16'h007F);
    start();
    run(-1, 200);
    chk("ban_fall_pc", pc, 8'h03);
    chk("ban_fall_acc", acc, 8'h7F);

    // PC wrap from 0xFF to 0x00
    clear_mem();
    mem[0] = 16'h9010; mem[1] = 16'h80FF; mem[8'hFF] = 16'h1000;
    start();
    run(-1, 300);
    chk("wrap_halted", halted, 1);
    chk("wrap_pc", pc, 8'h11);
    chk("wrap_acc", acc, 8'hFF);

    // Reset while the LDA operand read is outstanding
    load_p1();
    start();
    for (int i = 0; i < 60; i++) begin
      tick(4);
      if (in_txn && !cur.fetch) break;
    end
    chk("mid_rd_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_pc", pc, 8'h00);
    chk("mid_rst_acc", acc, 8'h00);
    start();
    run(-1, 300);
    check_p1("after_rst");

    // Random programs with random wait states
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 256; i++)
        mem[i] = {4'($urandom_range(0, 15)), 4'h0, 8'($urandom)};
      start();
      run(-1, 300);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
